// File: rtl/spm_dma_pkg.sv
// spm_dma_pkg: shared widths, FSM state encoding, mode and SPM strobe polarities for spm_dma.
package spm_dma_pkg;
   localparam int SPM_ADDR_W = 12;
   localparam int SPM_DATA_W = 32;
   localparam logic SPM_DMA_COPY = 1'b0;
   localparam logic SPM_DMA_FILL = 1'b1;
   localparam logic SPM_READ = 1'b1;
   localparam logic SPM_WRITE = 1'b0;
   localparam logic SPM_AS_ENABLE = 1'b0;
   localparam logic SPM_AS_DISABLE = 1'b1;
   typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_CAPT, ST_WRITE, ST_DONE} state_e;
endpackage

// File: rtl/spm_dma.sv
// spm_dma: SPM block copy/fill engine issuing grant-qualified strobes on a shared SPM port.
module spm_dma
   import spm_dma_pkg::*;
#(
   parameter int ADDR_W = SPM_ADDR_W,
   parameter int DATA_W = SPM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] spm_addr,
   output logic              spm_as_,
   output logic              spm_rw,
   output logic [DATA_W-1:0] spm_wr_data,
   input  logic [DATA_W-1:0] spm_rd_data,
   input  logic              spm_gnt
);
   state_e state_q, state_d;
   logic mode_q, mode_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q;
   logic [ADDR_W:0] rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d, fill_q, fill_d, wr_q;
   logic busy_q, done_q, as_q, rw_q;
   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      src_d = src_q;
      dst_d = dst_q;
      rem_d = rem_q;
      data_d = data_q;
      fill_d = fill_q;
      case (state_q)
         ST_IDLE: if (start) begin
            mode_d = mode;
            src_d = src_addr;
            dst_d = dst_addr;
            rem_d = len;
            fill_d = fill_data;
            state_d = len == '0 ? ST_DONE : mode == SPM_DMA_COPY ? ST_READ : ST_WRITE;
         end
         ST_READ: state_d = spm_gnt ? ST_CAPT : ST_READ;
         ST_CAPT: begin
            data_d = spm_rd_data;
            state_d = ST_WRITE;
         end
         ST_WRITE: if (spm_gnt) begin
            src_d = src_q + ADDR_W'(1);
            dst_d = dst_q + ADDR_W'(1);
            rem_d = rem_q - (ADDR_W+1)'(1);
            state_d = rem_q == (ADDR_W+1)'(1) ? ST_DONE : mode_q == SPM_DMA_FILL ? ST_WRITE : ST_READ;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   // Outputs are registered from the next state so strobes appear in the cycle the state is entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q <= SPM_DMA_COPY;
         src_q <= '0;
         dst_q <= '0;
         rem_q <= '0;
         data_q <= '0;
         fill_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         as_q <= SPM_AS_DISABLE;
         rw_q <= SPM_READ;
         addr_q <= '0;
         wr_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         src_q <= src_d;
         dst_q <= dst_d;
         rem_q <= rem_d;
         data_q <= data_d;
         fill_q <= fill_d;
         busy_q <= state_d != ST_IDLE;
         done_q <= state_d == ST_DONE;
         as_q <= (state_d == ST_READ || state_d == ST_WRITE) ? SPM_AS_ENABLE : SPM_AS_DISABLE;
         rw_q <= state_d == ST_WRITE ? SPM_WRITE : SPM_READ;
         addr_q <= state_d == ST_READ ? src_d : state_d == ST_WRITE ? dst_d : addr_q;
         wr_q <= state_d != ST_WRITE ? wr_q : mode_d == SPM_DMA_FILL ? fill_d : data_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign spm_as_ = as_q;
   assign spm_rw = rw_q;
   assign spm_addr = addr_q;
   assign spm_wr_data = wr_q;
endmodule

// File: tb/tb_spm_dma.sv
// tb_spm_dma: randomized and directed checks of spm_dma against a word-level copy/fill memory model.
module tb_spm_dma;
   localparam int AW = 12;
   localparam int DW = 32;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, spm_gnt = 1'b1;
   logic [AW-1:0] src_addr = '0, dst_addr = '0;
   logic [AW:0] len = '0;
   logic [DW-1:0] fill_data = '0, spm_rd_data;
   logic busy, done, spm_as_, spm_rw;
   logic [AW-1:0] spm_addr;
   logic [DW-1:0] spm_wr_data;
   int tests = 0, fails = 0;
   logic [DW-1:0] mem [4096];
   logic [DW-1:0] refm [4096];
   typedef struct {int cyc; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
   wr_t wlog [$];
   logic as_log [1024];
   logic [AW-1:0] addr_log [1024];
   spm_dma dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .fill_data(fill_data), .busy(busy), .done(done),
      .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
      .spm_rd_data(spm_rd_data), .spm_gnt(spm_gnt)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (!spm_as_ && spm_gnt) begin
         if (spm_rw) spm_rd_data <= mem[spm_addr];
         else mem[spm_addr] <= spm_wr_data;
      end
   end
   // Cycle i counts from the start edge k: cycle i is the interval after edge k+i-1.
   task automatic run_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] n, input logic [DW-1:0] f, input int gk,
                           input int restart, output int done_at, output int stalls,
                           output int dones, output int as_low);
      wr_t w;
      wlog.delete();
      done_at = -1; stalls = 0; dones = 0; as_low = 0;
      @(negedge clk);
      mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f; start = 1'b1; spm_gnt = 1'b1;
      @(posedge clk);
      for (int i = 1; i < 1000; i++) begin
         @(negedge clk);
         start = (i == restart);
         if (i == restart) begin
            dst_addr = d ^ 12'h800; fill_data = ~f; mode = ~m; len = 13'd7;
         end
         spm_gnt = gk == 0 ? 1'b1 : gk == 1 ? ($urandom_range(0, 3) != 0) : !(i == 1 || i == 2 || i == 5);
         as_log[i] = spm_as_;
         addr_log[i] = spm_addr;
         if (!spm_as_) begin
            as_low++;
            if (!spm_gnt) stalls++;
            else if (!spm_rw) begin
               w.cyc = i; w.a = spm_addr; w.d = spm_wr_data;
               wlog.push_back(w);
            end
         end
         if (done) begin
            dones++;
            if (done_at < 0) done_at = i;
         end
         if (done_at >= 0 && i >= done_at + 4) break;
      end
      start = 1'b0; spm_gnt = 1'b1;
      tests++;
      if (done_at < 0) begin
         fails++;
         $display("FAIL xfer_timeout: done never seen, required within 1000 cycles");
      end
   endtask
   task automatic test_reset();
      for (int a = 0; a < 4096; a++) mem[a] = $urandom;
      repeat (3) @(negedge clk);
      tests++;
      if ({busy, done, spm_as_, spm_rw, spm_addr, spm_wr_data} !== {1'b0, 1'b0, 1'b1, 1'b1, 12'h0, 32'h0}) begin
         fails++;
         $display("FAIL reset_outputs: busy=%b done=%b as_=%b rw=%b addr=%h wd=%h, required 0 0 1 1 000 00000000",
                  busy, done, spm_as_, spm_rw, spm_addr, spm_wr_data);
      end
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || spm_as_ !== 1'b1) begin
         fails++;
         $display("FAIL idle_after_reset: busy=%b as_=%b, required 0 1", busy, spm_as_);
      end
   endtask
   task automatic test_fill();
      int da, st, dn, al;
      run_xfer(1'b1, 12'h0, 12'h100, 13'd4, 32'hDEADBEEF, 0, 0, da, st, dn, al);
      tests++;
      if (da != 5) begin fails++; $display("FAIL fill_done_cycle: got %0d, required 5", da); end
      tests++;
      if (wlog.size() != 4) begin fails++; $display("FAIL fill_write_count: got %0d, required 4", wlog.size()); end
      for (int j = 0; j < 4 && j < wlog.size(); j++) begin
         tests++;
         if (wlog[j].cyc != j + 1 || wlog[j].a !== 12'(12'h100 + j) || wlog[j].d !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL fill_write%0d: cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=deadbeef",
                     j, wlog[j].cyc, wlog[j].a, wlog[j].d, j + 1, 12'(12'h100 + j));
         end
      end
      for (int j = 0; j < 4; j++) begin
         tests++;
         if (mem[12'h100 + j] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL fill_mem%0d: got %h, required deadbeef", j, mem[12'h100 + j]);
         end
      end
   endtask
   task automatic test_copy();
      int da, st, dn, al;
      mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
      run_xfer(1'b0, 12'h0, 12'h800, 13'd3, 32'h0, 0, 0, da, st, dn, al);
      tests++;
      if (da != 10) begin fails++; $display("FAIL copy_done_cycle: got %0d, required 10", da); end
      tests++;
      if (wlog.size() != 3) begin fails++; $display("FAIL copy_write_count: got %0d, required 3", wlog.size()); end
      for (int j = 0; j < 3 && j < wlog.size(); j++) begin
         tests++;
         if (wlog[j].cyc != 3 * (j + 1) || wlog[j].a !== 12'(12'h800 + j) || wlog[j].d !== DW'(j + 1)) begin
            fails++;
            $display("FAIL copy_write%0d: cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%0d",
                     j, wlog[j].cyc, wlog[j].a, wlog[j].d, 3 * (j + 1), 12'(12'h800 + j), j + 1);
         end
      end
      tests++;
      if ({mem[12'h800], mem[12'h801], mem[12'h802]} !== {32'd1, 32'd2, 32'd3}) begin
         fails++;
         $display("FAIL copy_mem: got %h %h %h, required 1 2 3", mem[12'h800], mem[12'h801], mem[12'h802]);
      end
   endtask
   task automatic test_stall();
      int da, st, dn, al;
      mem[12'h10] = 32'hA5A51234;
      run_xfer(1'b0, 12'h10, 12'h20, 13'd1, 32'h0, 2, 0, da, st, dn, al);
      tests++;
      if (da != 7) begin fails++; $display("FAIL stall_done_cycle: got %0d, required 7", da); end
      for (int i = 1; i <= 6; i++) begin
         tests++;
         if (i == 4 ? as_log[i] !== 1'b1
                    : (as_log[i] !== 1'b0 || addr_log[i] !== (i < 4 ? 12'h10 : 12'h20))) begin
            fails++;
            $display("FAIL stall_hold%0d: as_=%b addr=%h, required as_=%b addr=%h",
                     i, as_log[i], addr_log[i], i == 4, i < 4 ? 12'h10 : 12'h20);
         end
      end
      tests++;
      if (mem[12'h20] !== 32'hA5A51234) begin
         fails++;
         $display("FAIL stall_mem: got %h, required a5a51234", mem[12'h20]);
      end
   endtask
   task automatic test_wrap_zero();
      int da, st, dn, al;
      logic [AW-1:0] exp_a [4];
      exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
      run_xfer(1'b1, 12'h0, 12'hFFE, 13'd4, 32'h12345678, 0, 0, da, st, dn, al);
      tests++;
      if (wlog.size() != 4) begin fails++; $display("FAIL wrap_count: got %0d, required 4", wlog.size()); end
      for (int j = 0; j < 4 && j < wlog.size(); j++) begin
         tests++;
         if (wlog[j].a !== exp_a[j] || mem[exp_a[j]] !== 32'h12345678) begin
            fails++;
            $display("FAIL wrap_addr%0d: addr=%h mem=%h, required addr=%h mem=12345678",
                     j, wlog[j].a, mem[exp_a[j]], exp_a[j]);
         end
      end
      run_xfer(1'b0, 12'h5, 12'h6, 13'd0, 32'h0, 0, 0, da, st, dn, al);
      tests++;
      if (da != 1 || al != 0 || dn != 1) begin
         fails++;
         $display("FAIL zero_len: done_at=%0d as_low=%0d dones=%0d, required 1 0 1", da, al, dn);
      end
   endtask
   task automatic test_back_to_back();
      int da, st, dn, al;
      run_xfer(1'b1, 12'h0, 12'h300, 13'd6, 32'hCAFEF00D, 0, 2, da, st, dn, al);
      tests++;
      if (dn != 1 || da != 7) begin
         fails++;
         $display("FAIL busy_start: dones=%0d done_at=%0d, required 1 7", dn, da);
      end
      tests++;
      if (wlog.size() != 6 || wlog[0].a !== 12'h300 || wlog[wlog.size()-1].a !== 12'h305) begin
         fails++;
         $display("FAIL busy_start_writes: count=%0d, required 6 writes to 300..305", wlog.size());
      end
   endtask
   task automatic test_reset_mid();
      int seen = 0;
      @(negedge clk);
      mode = 1'b0; src_addr = 12'h40; dst_addr = 12'h60; len = 13'd8; start = 1'b1; spm_gnt = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || spm_as_ !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: busy=%b as_=%b done=%b, required 0 1 0", busy, spm_as_, done);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      tests++;
      if (seen != 0) begin fails++; $display("FAIL reset_mid_quiet: %0d active cycles, required 0", seen); end
   endtask
   task automatic test_random();
      int da, st, dn, al, diffs;
      logic m;
      logic [AW-1:0] s, d;
      logic [AW:0] n;
      logic [DW-1:0] f;
      for (int a = 0; a < 4096; a++) refm[a] = mem[a];
      for (int t = 0; t < 10; t++) begin
         m = 1'($urandom_range(0, 1));
         s = 12'($urandom); d = 12'($urandom);
         n = 13'($urandom_range(1, 20));
         f = $urandom;
         for (int j = 0; j < int'(n); j++) refm[12'(d + j)] = m ? f : refm[12'(s + j)];
         run_xfer(m, s, d, n, f, 1, 0, da, st, dn, al);
         tests++;
         if (da != (m ? int'(n) + 1 : 3 * int'(n) + 1) + st) begin
            fails++;
            $display("FAIL rand%0d_done_cycle: got %0d, required %0d", t, da,
                     (m ? int'(n) + 1 : 3 * int'(n) + 1) + st);
         end
         diffs = 0;
         for (int a = 0; a < 4096; a++) if (mem[a] !== refm[a]) diffs++;
         tests++;
         if (diffs != 0 || wlog.size() != int'(n)) begin
            fails++;
            $display("FAIL rand%0d_mem: %0d words differ, %0d writes, required 0 and %0d", t, diffs, wlog.size(), n);
         end
      end
   endtask
   initial begin
      test_reset();
      test_fill();
      test_copy();
      test_stall();
      test_wrap_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
